tlb_op_seq: RTL and testbench
=============================

TLB_OP_SEQ -- requirements
Module: tlb_op_seq

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries (power of two; index width IW = log2(TLBNUM)).
REQ-002 SHALL have ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  TLB op request from WB stage
- req_ready  out  1  request accepted this cycle when both high
- req_op  in  3  0 srch, 1 rd, 2 wr, 3 fill, 4 invtlb, 5-7 illegal
- req_inv_op  in  5  invtlb op code
- req_pc  in  32  PC of the TLB instruction
- csr_tlbidx_index  in  IW  TLBIDX.index from CSR file
- cancel  in  1  WB exception/ertn flush; aborts the op in progress
- tlb_s_req  out  1  search strobe to TLB port
- tlb_s_hit  in  1  search hit, valid one cycle after tlb_s_req
- tlb_s_index  in  IW  hit index, valid with tlb_s_hit
- tlb_r_index  out  IW  read index
- csr_rd_we  out  1  CSRs capture TLB read data
- tlb_we  out  1  TLB write strobe
- tlb_w_index  out  IW  write index
- tlb_inv_valid  out  1  invalidate strobe
- tlb_inv_op  out  5  invalidate op
- csr_srch_we  out  1  CSRs capture search result
- csr_srch_hit  out  1  search hit to TLBIDX.NE
- csr_srch_index  out  IW  search index to TLBIDX.index
- flush_valid  out  1  refetch flush to fetch stage
- flush_pc  out  32  refetch target
- busy  out  1  high in any state other than IDLE

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, WAIT, FLUSH; busy = (state != IDLE).
REQ-004 IDLE: req_ready = ~cancel; on req_valid & req_ready capture op, inv_op, pc, csr_tlbidx_index into registers, go to ISSUE.
REQ-005 ISSUE, srch: tlb_s_req=1 one cycle, go to WAIT.
REQ-006 ISSUE, rd: tlb_r_index=captured index, csr_rd_we=1 one cycle, go to FLUSH.
REQ-007 ISSUE, wr: tlb_we=1, tlb_w_index=captured index, one cycle, go to FLUSH.
REQ-008 ISSUE, fill: tlb_we=1, tlb_w_index=fill_ptr, one cycle; fill_ptr increments, wrapping TLBNUM-1 to 0; go to FLUSH.
REQ-009 ISSUE, invtlb: tlb_inv_valid=1, tlb_inv_op=captured inv_op, only if inv_op <= 6; inv_op > 6 gives no strobe; go to FLUSH either way.
REQ-010 ISSUE, illegal op (5-7): no strobe, go to FLUSH.
REQ-011 WAIT: csr_srch_we=1, csr_srch_hit=tlb_s_hit, csr_srch_index=tlb_s_index, one cycle, go to FLUSH.
REQ-012 FLUSH: flush_valid=1, flush_pc=captured pc+4 (mod 2^32), one cycle, go to IDLE.
REQ-013 Latency from accept cycle T: side-effect strobe at T+1; flush at T+2 (T+3 for srch); req_ready high again at T+3 (T+4 for srch).
REQ-014 Every strobe SHALL be high for exactly one cycle per accepted op; at most one of tlb_s_req, csr_rd_we, tlb_we, tlb_inv_valid, csr_srch_we, flush_valid is high in any cycle.
REQ-015 cancel in ISSUE or WAIT SHALL suppress that cycle's strobes, skip FLUSH and return to IDLE next cycle; fill_ptr unchanged.
REQ-016 cancel in FLUSH SHALL be ignored; flush_valid still asserts.
REQ-017 cancel and req_valid together in IDLE: request not accepted.
REQ-018 Strobe outputs SHALL be decoded from state and captured registers, gated by ~cancel; index/data outputs SHALL be 0 when their strobe is low.

Reset
REQ-019 On reset: state IDLE, fill_ptr 0, captured registers 0; all strobes 0, flush_pc 0, busy 0, req_ready 1 (when cancel low).
REQ-020 Reset mid-operation SHALL abort the op with no strobe in the following cycle.

Verification
REQ-021 tlbwr, csr_tlbidx_index=5, pc=0x1C000100 -> tlb_we=1 w_index=5 at T+1; flush_valid=1, flush_pc=0x1C000104 at T+2; req_ready=1 at T+3.
REQ-022 17 back-to-back tlbfill ops (TLBNUM=16) -> w_index 0,1,...,15,0; one flush each.
REQ-023 tlbsrch with tlb_s_hit=1, tlb_s_index=9 -> tlb_s_req at T+1, csr_srch_we with hit=1, index=9 at T+2, flush at T+3.
REQ-024 invtlb inv_op=7 -> no tlb_inv_valid; flush at T+2; invtlb inv_op=2 -> tlb_inv_valid=1, tlb_inv_op=2 at T+1.
REQ-025 cancel at T+1 of tlbwr -> no tlb_we, no flush, IDLE at T+2; cancel in FLUSH -> flush still issued.
REQ-026 reset asserted in WAIT -> no csr_srch_we, no flush; busy=0 next cycle.

Source files
------------

// File: rtl/tlb_op_seq_if.sv
// rtl/tlb_op_seq_if.sv - request, TLB port, CSR and flush signal bundle for the TLB op sequencer
interface tlb_op_seq_if #(
    parameter int TLBNUM = 16
);
    localparam int IW = $clog2(TLBNUM);

    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [4:0]    req_inv_op;
    logic [31:0]   req_pc;
    logic [IW-1:0] csr_tlbidx_index;
    logic          cancel;
    logic          tlb_s_req;
    logic          tlb_s_hit;
    logic [IW-1:0] tlb_s_index;
    logic [IW-1:0] tlb_r_index;
    logic          csr_rd_we;
    logic          tlb_we;
    logic [IW-1:0] tlb_w_index;
    logic          tlb_inv_valid;
    logic [4:0]    tlb_inv_op;
    logic          csr_srch_we;
    logic          csr_srch_hit;
    logic [IW-1:0] csr_srch_index;
    logic          flush_valid;
    logic [31:0]   flush_pc;
    logic          busy;

    modport master (
        output req_valid, req_op, req_inv_op, req_pc, csr_tlbidx_index, cancel,
               tlb_s_hit, tlb_s_index,
        input  req_ready, tlb_s_req, tlb_r_index, csr_rd_we, tlb_we, tlb_w_index,
               tlb_inv_valid, tlb_inv_op, csr_srch_we, csr_srch_hit, csr_srch_index,
               flush_valid, flush_pc, busy
    );

    modport slave (
        input  req_valid, req_op, req_inv_op, req_pc, csr_tlbidx_index, cancel,
               tlb_s_hit, tlb_s_index,
        output req_ready, tlb_s_req, tlb_r_index, csr_rd_we, tlb_we, tlb_w_index,
               tlb_inv_valid, tlb_inv_op, csr_srch_we, csr_srch_hit, csr_srch_index,
               flush_valid, flush_pc, busy
    );
endinterface

// File: rtl/tlb_op_seq.sv
// rtl/tlb_op_seq.sv - sequences TLB srch/rd/wr/fill/invtlb ops from WB into TLB/CSR strobes and a refetch flush
module tlb_op_seq #(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        reset,
    tlb_op_seq_if.slave bus
);
    localparam int IW = $clog2(TLBNUM);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [4:0]    inv_op_q, inv_op_d;
    logic [31:0]   pc_q, pc_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] fill_ptr_q, fill_ptr_d;

    logic          live;
    logic          s_req_raw, rd_raw, we_raw, inv_raw, srch_raw, flush_raw;
    logic [IW-1:0] w_index_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            inv_op_q   <= '0;
            pc_q       <= '0;
            idx_q      <= '0;
            fill_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            inv_op_q   <= inv_op_d;
            pc_q       <= pc_d;
            idx_q      <= idx_d;
            fill_ptr_q <= fill_ptr_d;
        end
    end

    // Side-effect strobes are killed by cancel (and reset) in the same cycle;
    // the flush is never cancellable once FLUSH is reached.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        inv_op_d    = inv_op_q;
        pc_d        = pc_q;
        idx_d       = idx_q;
        fill_ptr_d  = fill_ptr_q;
        live        = ~bus.cancel & ~reset;
        s_req_raw   = 1'b0;
        rd_raw      = 1'b0;
        we_raw      = 1'b0;
        inv_raw     = 1'b0;
        srch_raw    = 1'b0;
        flush_raw   = 1'b0;
        w_index_raw = idx_q;
        bus.req_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = ~bus.cancel;
                if (bus.req_valid && !bus.cancel) begin
                    op_d     = bus.req_op;
                    inv_op_d = bus.req_inv_op;
                    pc_d     = bus.req_pc;
                    idx_d    = bus.csr_tlbidx_index;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FLUSH;
                    case (op_q)
                        OP_SRCH: begin
                            s_req_raw = 1'b1;
                            state_d   = S_WAIT;
                        end
                        OP_RD:   rd_raw = 1'b1;
                        OP_WR:   we_raw = 1'b1;
                        OP_FILL: begin
                            we_raw      = 1'b1;
                            w_index_raw = fill_ptr_q;
                            fill_ptr_d  = fill_ptr_q + 1'b1;
                        end
                        OP_INV:  inv_raw = (inv_op_q <= 5'd6);
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                srch_raw = 1'b1;
                state_d  = bus.cancel ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: begin
                flush_raw = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        bus.busy           = (state_q != S_IDLE);
        bus.tlb_s_req      = s_req_raw & live;
        bus.csr_rd_we      = rd_raw & live;
        bus.tlb_we         = we_raw & live;
        bus.tlb_inv_valid  = inv_raw & live;
        bus.csr_srch_we    = srch_raw & live;
        bus.flush_valid    = flush_raw & ~reset;
        bus.tlb_r_index    = bus.csr_rd_we ? idx_q : '0;
        bus.tlb_w_index    = bus.tlb_we ? w_index_raw : '0;
        bus.tlb_inv_op     = bus.tlb_inv_valid ? inv_op_q : 5'd0;
        bus.csr_srch_hit   = bus.csr_srch_we & bus.tlb_s_hit;
        bus.csr_srch_index = bus.csr_srch_we ? bus.tlb_s_index : '0;
        bus.flush_pc       = bus.flush_valid ? (pc_q + 32'd4) : 32'd0;
    end
endmodule

// File: tb/tb_tlb_op_seq.sv
// tb/tb_tlb_op_seq.sv - randomized and directed bench for tlb_op_seq against a per-op timeline model
module tb_tlb_op_seq;
    localparam int TLBNUM = 16;
    localparam int IW     = $clog2(TLBNUM);
    localparam int DW     = 3 * IW + 38;
    localparam logic [IW-1:0] ZI = '0;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   model_fill;

    tlb_op_seq_if #(.TLBNUM(TLBNUM)) bus ();

    tlb_op_seq #(.TLBNUM(TLBNUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one op starting in the current cycle (accept cycle T) and checks every
    // cycle up to, but excluding, the cycle where the sequencer is ready again.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] inv,
                          input logic [31:0] pc, input logic [IW-1:0] idx, input logic hit,
                          input logic [IW-1:0] sidx, input int cancel_at);
        int            flush_k;
        int            ready_k;
        bit            aborted;
        bit            c;
        logic [5:0]    e_stb, o_stb;
        logic [DW-1:0] e_dat, o_dat;
        logic [1:0]    e_st, o_st;
        flush_k = (op == 3'd0) ? 3 : 2;
        aborted = (cancel_at >= 1) && (cancel_at < flush_k);
        ready_k = aborted ? cancel_at + 1 : flush_k + 1;

        bus.req_valid        = 1'b1;
        bus.req_op           = op;
        bus.req_inv_op       = inv;
        bus.req_pc           = pc;
        bus.csr_tlbidx_index = idx;
        bus.cancel           = 1'b0;
        @(negedge clk);
        o_stb = {bus.tlb_s_req, bus.csr_rd_we, bus.tlb_we, bus.tlb_inv_valid, bus.csr_srch_we, bus.flush_valid};
        checks++;
        if ({bus.req_ready, bus.busy} !== 2'b10 || o_stb !== 6'b0) begin
            errors++;
            $display("FAIL %s accept: ready,busy=%b strobes=%b, required ready,busy=10 strobes=000000",
                     tag, {bus.req_ready, bus.busy}, o_stb);
        end
        @(posedge clk); #1;

        for (int k = 1; k < ready_k; k++) begin
            c = (k == cancel_at);
            bus.cancel           = c;
            bus.req_valid        = 1'($urandom_range(0, 1));
            bus.req_op           = 3'($urandom);
            bus.req_inv_op       = 5'($urandom);
            bus.req_pc           = $urandom;
            bus.csr_tlbidx_index = IW'($urandom);
            bus.tlb_s_hit        = (op == 3'd0 && k == 2) ? hit : 1'($urandom);
            bus.tlb_s_index      = (op == 3'd0 && k == 2) ? sidx : IW'($urandom);
            @(negedge clk);
            e_stb[5] = !c && op == 3'd0 && k == 1;
            e_stb[4] = !c && op == 3'd1 && k == 1;
            e_stb[3] = !c && (op == 3'd2 || op == 3'd3) && k == 1;
            e_stb[2] = !c && op == 3'd4 && inv <= 5'd6 && k == 1;
            e_stb[1] = !c && op == 3'd0 && k == 2;
            e_stb[0] = !aborted && k == flush_k;
            e_dat = {e_stb[4] ? idx : ZI,
                     e_stb[3] ? ((op == 3'd3) ? IW'(model_fill) : idx) : ZI,
                     e_stb[2] ? inv : 5'd0,
                     e_stb[1] ? hit : 1'b0,
                     e_stb[1] ? sidx : ZI,
                     e_stb[0] ? pc + 32'd4 : 32'd0};
            e_st  = 2'b01;
            o_stb = {bus.tlb_s_req, bus.csr_rd_we, bus.tlb_we, bus.tlb_inv_valid, bus.csr_srch_we, bus.flush_valid};
            o_dat = {bus.tlb_r_index, bus.tlb_w_index, bus.tlb_inv_op, bus.csr_srch_hit,
                     bus.csr_srch_index, bus.flush_pc};
            o_st  = {bus.req_ready, bus.busy};
            checks++;
            if (o_stb !== e_stb) begin
                errors++;
                $display("FAIL %s strobes T+%0d: got %b required %b", tag, k, o_stb, e_stb);
            end
            checks++;
            if (o_dat !== e_dat) begin
                errors++;
                $display("FAIL %s data T+%0d: got %h required %h", tag, k, o_dat, e_dat);
            end
            checks++;
            if (o_st !== e_st) begin
                errors++;
                $display("FAIL %s ready,busy T+%0d: got %b required %b", tag, k, o_st, e_st);
            end
            @(posedge clk); #1;
        end
        bus.cancel    = 1'b0;
        bus.req_valid = 1'b0;
        if (op == 3'd3 && !aborted) model_fill = (model_fill + 1) % TLBNUM;
    endtask

    task automatic test_reset;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.cancel     = 1'b0;
        bus.req_op     = '0;
        bus.req_inv_op = '0;
        bus.req_pc     = '0;
        bus.csr_tlbidx_index = '0;
        bus.tlb_s_hit  = 1'b0;
        bus.tlb_s_index = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.busy, bus.tlb_s_req, bus.csr_rd_we, bus.tlb_we, bus.tlb_inv_valid,
             bus.csr_srch_we, bus.flush_valid} !== 8'b10000000 || bus.flush_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ready,busy,strobes=%b flush_pc=%h required 10000000 and 0",
                     {bus.req_ready, bus.busy, bus.tlb_s_req, bus.csr_rd_we, bus.tlb_we,
                      bus.tlb_inv_valid, bus.csr_srch_we, bus.flush_valid}, bus.flush_pc);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_fill = 0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.busy} !== 2'b10 || bus.tlb_w_index !== ZI) begin
            errors++;
            $display("FAIL post_reset: ready,busy=%b w_index=%0d required 10 and 0",
                     {bus.req_ready, bus.busy}, bus.tlb_w_index);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wr_directed;
        run_op("wr_idx5", 3'd2, 5'd0, 32'h1C00_0100, IW'(5), 1'b0, ZI, 0);
        run_op("rd_idx11", 3'd1, 5'd0, 32'h1C00_0200, IW'(11), 1'b0, ZI, 0);
    endtask

    task automatic test_fill_back_to_back;
        for (int i = 0; i < 17; i++)
            run_op("fill_b2b", 3'd3, 5'($urandom), $urandom, IW'($urandom), 1'b0, ZI, 0);
        checks++;
        if (model_fill != 1) begin
            errors++;
            $display("FAIL fill_count: model pointer %0d required 1", model_fill);
        end
    endtask

    task automatic test_srch;
        run_op("srch_hit9", 3'd0, 5'd0, 32'h1C00_0300, IW'(3), 1'b1, IW'(9), 0);
        run_op("srch_miss", 3'd0, 5'd0, 32'hFFFF_FFFC, IW'(3), 1'b0, IW'(6), 0);
    endtask

    task automatic test_invtlb;
        run_op("inv_op7", 3'd4, 5'd7, 32'h1C00_0400, ZI, 1'b0, ZI, 0);
        run_op("inv_op2", 3'd4, 5'd2, 32'h1C00_0404, ZI, 1'b0, ZI, 0);
        run_op("inv_op6", 3'd4, 5'd6, 32'h1C00_0408, ZI, 1'b0, ZI, 0);
        run_op("illegal5", 3'd5, 5'd1, 32'h1C00_040C, IW'(2), 1'b0, ZI, 0);
        run_op("illegal7", 3'd7, 5'd1, 32'h1C00_0410, IW'(2), 1'b0, ZI, 0);
    endtask

    task automatic test_cancel;
        run_op("cancel_wr_issue", 3'd2, 5'd0, 32'h1C00_0500, IW'(4), 1'b0, ZI, 1);
        run_op("cancel_wr_flush", 3'd2, 5'd0, 32'h1C00_0504, IW'(4), 1'b0, ZI, 2);
        run_op("cancel_srch_wait", 3'd0, 5'd0, 32'h1C00_0508, ZI, 1'b1, IW'(7), 2);
        run_op("cancel_fill_issue", 3'd3, 5'd0, 32'h1C00_050C, ZI, 1'b0, ZI, 1);
        run_op("fill_after_cancel", 3'd3, 5'd0, 32'h1C00_0510, ZI, 1'b0, ZI, 0);
    endtask

    task automatic test_cancel_idle;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd2;
        bus.cancel    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle_ready: got %b required 0", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.cancel    = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.tlb_we, bus.flush_valid, bus.req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL cancel_idle_not_taken: busy,we,flush,ready=%b required 0001",
                     {bus.busy, bus.tlb_we, bus.flush_valid, bus.req_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        int fk;
        int ca;
        logic [2:0] op;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            fk = (op == 3'd0) ? 3 : 2;
            ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, fk)) : 0;
            run_op("random", op, 5'($urandom_range(0, 9)), $urandom, IW'($urandom),
                   1'($urandom), IW'($urandom), ca);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset_in_wait;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_pc    = 32'h1C00_0600;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.tlb_s_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_sreq: got %b required 1", bus.tlb_s_req);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        bus.tlb_s_hit = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.csr_srch_we, bus.flush_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rst_wait_cycle: srch_we,flush=%b required 00", {bus.csr_srch_we, bus.flush_valid});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_fill = 0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.csr_srch_we, bus.flush_valid, bus.req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rst_wait_after: busy,srch_we,flush,ready=%b required 0001",
                     {bus.busy, bus.csr_srch_we, bus.flush_valid, bus.req_ready});
        end
        @(posedge clk); #1;
        run_op("fill_after_reset", 3'd3, 5'd0, 32'h1C00_0700, IW'(9), 1'b0, ZI, 0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        model_fill = 0;
        test_reset();
        test_wr_directed();
        test_fill_back_to_back();
        test_srch();
        test_invtlb();
        test_cancel();
        test_cancel_idle();
        test_random();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
